// File: rtl/trace_scheduler_pkg.sv
// trace_scheduler_pkg: shared constants and FSM encoding for the column trace scheduler.
//   NUM_COLS  columns traced per frame (buffer addresses 0..NUM_COLS-1)
//   COL_W     width of column index / buffer address
//   HEIGHT_W  wall height width
//   MAP_W     map_rom row/column address width
//   TIMEOUT   cycles a column may wait for the tracer before a forced store
package trace_scheduler_pkg;

    localparam int unsigned NUM_COLS = 640;
    localparam int unsigned COL_W    = 10;
    localparam int unsigned HEIGHT_W = 8;
    localparam int unsigned MAP_W    = 4;
    localparam int unsigned TIMEOUT  = 255;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StWait  = 2'd2,
        StStore = 2'd3
    } state_e;

endpackage

// File: rtl/trace_scheduler_if.sv
// trace_scheduler_if: tracer job handshake plus trace_buffer write bus.
//   master (scheduler): drives col_start/col_abort/col_index and buf_*, receives col_done/side/height
//   slave  (tracer + buffer): the mirror image
interface trace_scheduler_if;
    import trace_scheduler_pkg::*;

    logic                col_start;
    logic                col_abort;
    logic [COL_W-1:0]    col_index;
    logic                col_done;
    logic                col_side;
    logic [HEIGHT_W-1:0] col_height;
    logic                buf_we;
    logic [COL_W-1:0]    buf_addr;
    logic                buf_side;
    logic [HEIGHT_W-1:0] buf_height;

    modport master (
        output col_start, col_abort, col_index, buf_we, buf_addr, buf_side, buf_height,
        input  col_done, col_side, col_height
    );

    modport slave (
        input  col_start, col_abort, col_index, buf_we, buf_addr, buf_side, buf_height,
        output col_done, col_side, col_height
    );

endinterface

// File: rtl/trace_scheduler_map_rom_arb.sv
// map_rom_arb: combinational owner select for the single map_rom port.
//   visible         display active; the overlay owns the ROM
//   disp_col/row    overlay address
//   trc_req         tracer read request
//   trc_col/row     tracer address
//   map_col/row     muxed ROM address
//   trc_gnt         ROM data valid for the tracer this cycle
module map_rom_arb
    import trace_scheduler_pkg::*;
(
    input  logic             visible,
    input  logic [MAP_W-1:0] disp_col,
    input  logic [MAP_W-1:0] disp_row,
    input  logic             trc_req,
    input  logic [MAP_W-1:0] trc_col,
    input  logic [MAP_W-1:0] trc_row,
    output logic [MAP_W-1:0] map_col,
    output logic [MAP_W-1:0] map_row,
    output logic             trc_gnt
);

    always_comb begin
        map_col = visible ? disp_col : trc_col;
        map_row = visible ? disp_row : trc_row;
        trc_gnt = trc_req & ~visible;
    end

endmodule

// File: rtl/trace_scheduler.sv
// trace_scheduler: runs one tracer job per screen column during vblank and stores each
// result into trace_buffer; shares map_rom between the display overlay and the tracer.
//   clk, reset            pixel clock, asynchronous active-low reset
//   vblank, visible       timing from vga_sync
//   disp_map_col/row      overlay map address
//   map_col/row           muxed map_rom address
//   trc_req/col/row/gnt   tracer map read port
//   job                   tracer handshake and trace_buffer write bus (master side)
//   busy                  FSM not idle
//   overrun               sticky: a vblank ended before the frame was fully stored
//   timeouts              saturating count of columns the tracer never answered
module trace_scheduler
    import trace_scheduler_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                vblank,
    input  logic                visible,
    input  logic [MAP_W-1:0]    disp_map_col,
    input  logic [MAP_W-1:0]    disp_map_row,
    output logic [MAP_W-1:0]    map_col,
    output logic [MAP_W-1:0]    map_row,
    input  logic                trc_req,
    input  logic [MAP_W-1:0]    trc_col,
    input  logic [MAP_W-1:0]    trc_row,
    output logic                trc_gnt,
    trace_scheduler_if.master   job,
    output logic                busy,
    output logic                overrun,
    output logic [7:0]          timeouts
);

    state_e              state_q;
    logic                vblank_q;
    logic [COL_W-1:0]    col_q;
    logic [7:0]          tcnt_q;
    logic                side_q;
    logic [HEIGHT_W-1:0] height_q;
    logic                start_q;
    logic                abort_q;
    logic                we_q;
    logic                overrun_q;
    logic [7:0]          timeouts_q;

    map_rom_arb u_arb (
        .visible  (visible),
        .disp_col (disp_map_col),
        .disp_row (disp_map_row),
        .trc_req  (trc_req),
        .trc_col  (trc_col),
        .trc_row  (trc_row),
        .map_col  (map_col),
        .map_row  (map_row),
        .trc_gnt  (trc_gnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            vblank_q   <= 1'b0;
            col_q      <= '0;
            tcnt_q     <= '0;
            side_q     <= 1'b0;
            height_q   <= '0;
            start_q    <= 1'b0;
            abort_q    <= 1'b0;
            we_q       <= 1'b0;
            overrun_q  <= 1'b0;
            timeouts_q <= '0;
        end else begin
            vblank_q <= vblank;
            start_q  <= 1'b0;
            abort_q  <= 1'b0;
            we_q     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Only a fresh rising edge opens a frame, so a long vblank traces once.
                    if (vblank && !vblank_q) begin
                        col_q   <= '0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    start_q <= 1'b1;
                    tcnt_q  <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    // A result arriving with the vblank fall or the timeout is still kept.
                    if (job.col_done) begin
                        side_q   <= job.col_side;
                        height_q <= job.col_height;
                        we_q     <= ~visible;
                        state_q  <= StStore;
                    end else if (!vblank) begin
                        abort_q   <= 1'b1;
                        overrun_q <= 1'b1;
                        state_q   <= StIdle;
                    end else if (tcnt_q == 8'(TIMEOUT - 1)) begin
                        // Dead column: stored as zero height so the renderer shows a gap.
                        side_q   <= 1'b0;
                        height_q <= '0;
                        we_q     <= ~visible;
                        if (timeouts_q != 8'hFF) begin
                            timeouts_q <= timeouts_q + 8'd1;
                        end
                        state_q <= StStore;
                    end else begin
                        tcnt_q <= tcnt_q + 8'd1;
                    end
                end
                StStore: begin
                    if (col_q == COL_W'(NUM_COLS - 1)) begin
                        col_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        col_q <= col_q + 1'b1;
                        if (vblank) begin
                            state_q <= StStart;
                        end else begin
                            overrun_q <= 1'b1;
                            state_q   <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        job.col_start  = start_q;
        job.col_abort  = abort_q;
        job.col_index  = col_q;
        job.buf_we     = we_q & ~visible;
        job.buf_addr   = col_q;
        job.buf_side   = side_q;
        job.buf_height = height_q;
        busy           = (state_q != StIdle);
        overrun        = overrun_q;
        timeouts       = timeouts_q;
    end

endmodule

// File: tb/tb_trace_scheduler.sv
module tb_trace_scheduler;
    import trace_scheduler_pkg::*;

    typedef struct {
        int addr;
        int side;
        int height;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       vblank;
    logic       visible;
    logic [3:0] disp_map_col;
    logic [3:0] disp_map_row;
    logic [3:0] map_col;
    logic [3:0] map_row;
    logic       trc_req;
    logic [3:0] trc_col;
    logic [3:0] trc_row;
    logic       trc_gnt;
    logic       busy;
    logic       overrun;
    logic [7:0] timeouts;

    trace_scheduler_if job ();

    trace_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .vblank       (vblank),
        .visible      (visible),
        .disp_map_col (disp_map_col),
        .disp_map_row (disp_map_row),
        .map_col      (map_col),
        .map_row      (map_row),
        .trc_req      (trc_req),
        .trc_col      (trc_col),
        .trc_row      (trc_row),
        .trc_gnt      (trc_gnt),
        .job          (job),
        .busy         (busy),
        .overrun      (overrun),
        .timeouts     (timeouts)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   slow_col = -1;
    int   slow_delay = 0;
    int   silent_col = -1;
    int   silent_start = 0;
    int   writes = 0;
    int   aborts = 0;
    int   abort_col = -1;
    int   first_start_cyc = -1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Tracer model: answers each started column after a random delay, except the silent
    // column (never answers) and the slow column (fixed long delay).
    initial begin : tracer
        int   c;
        int   d;
        int   cnt;
        bit   pending;
        exp_t e;
        pending        = 0;
        c              = 0;
        d              = 0;
        cnt            = 0;
        job.col_done   = 1'b0;
        job.col_side   = 1'b0;
        job.col_height = '0;
        forever begin
            @(negedge clk);
            job.col_done = 1'b0;
            if (!reset) begin
                pending = 0;
                continue;
            end
            if (job.col_abort) pending = 0;
            if (job.col_start) begin
                c       = int'(job.col_index);
                cnt     = 0;
                d       = (c == slow_col) ? slow_delay : int'($urandom_range(1, 6));
                pending = (c != silent_col);
                if (c == silent_col) begin
                    silent_start = cyc;
                    e.addr   = c;
                    e.side   = 0;
                    e.height = 0;
                    exp_q.push_back(e);
                end
            end else if (pending) begin
                cnt++;
                if (cnt == d) begin
                    job.col_side   = 1'($urandom);
                    job.col_height = 8'($urandom);
                    job.col_done   = 1'b1;
                    e.addr   = c;
                    e.side   = int'(job.col_side);
                    e.height = int'(job.col_height);
                    exp_q.push_back(e);
                    pending = 0;
                end
            end
        end
    end

    // Monitor: every buffer write must match the oldest outstanding tracer result.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (job.buf_we) begin
                writes++;
                chk("we_while_visible", int'(visible), 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d expected no write",
                             job.buf_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("buf_addr", int'(job.buf_addr), e.addr);
                    chk("buf_side", int'(job.buf_side), e.side);
                    chk("buf_height", int'(job.buf_height), e.height);
                    if (e.addr == silent_col) chk("timeout_latency", cyc - silent_start, 255);
                end
            end
            if (job.col_abort) begin
                aborts++;
                abort_col = int'(job.col_index);
            end
            if (job.col_start && first_start_cyc < 0) first_start_cyc = cyc;
        end
    end

    task automatic wait_start(input int col);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(job.col_start && int'(job.col_index) == col) && n < 20000);
        chk($sformatf("start_col_%0d_seen", col), int'(n < 20000), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (5) @(negedge clk);
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_idle", int'(busy), 0);
    endtask

    initial begin : main
        int rise_cyc;
        int base;
        vblank       = 1'b0;
        visible      = 1'b0;
        disp_map_col = '0;
        disp_map_row = '0;
        trc_req      = 1'b0;
        trc_col      = '0;
        trc_row      = '0;
        reset        = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_col_index", int'(job.col_index), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_timeouts", int'(timeouts), 0);
        chk("rst_buf_we", int'(job.buf_we), 0);
        chk("rst_col_start", int'(job.col_start), 0);
        @(negedge clk);
        reset = 1'b1;

        // Map ROM arbitration
        for (int i = 0; i < 6; i++) begin
            disp_map_col = 4'($urandom);
            disp_map_row = 4'($urandom);
            trc_col      = 4'($urandom);
            trc_row      = 4'($urandom);
            visible      = (i % 3 == 0);
            trc_req      = (i % 3 != 2);
            #1;
            chk("map_col", int'(map_col), int'(visible ? disp_map_col : trc_col));
            chk("map_row", int'(map_row), int'(visible ? disp_map_row : trc_row));
            chk("trc_gnt", int'(trc_gnt), int'(trc_req && !visible));
            #2;
        end
        visible = 1'b0;
        trc_req = 1'b0;

        // Full frame, column 12 never answered
        silent_col = 12;
        base       = writes;
        @(posedge clk);
        #1;
        vblank   = 1'b1;
        rise_cyc = cyc;
        wait_idle();
        chk("start_latency", first_start_cyc - rise_cyc, 2);
        chk("frame_writes", writes - base, 640);
        chk("frame_timeouts", int'(timeouts), 1);
        chk("frame_overrun", int'(overrun), 0);
        chk("frame_col_wrap", int'(job.col_index), 0);
        chk("frame_queue_empty", exp_q.size(), 0);
        repeat (20) @(negedge clk);
        chk("level_vblank_no_start", int'(busy), 0);

        // vblank falls while column 100 is waiting
        silent_col = -1;
        vblank     = 1'b0;
        repeat (3) @(negedge clk);
        slow_col   = 100;
        slow_delay = 40;
        base       = writes;
        vblank     = 1'b1;
        wait_start(100);
        repeat (5) @(negedge clk);
        vblank = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_count", aborts, 1);
        chk("abort_col", abort_col, 100);
        chk("abort_overrun", int'(overrun), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_writes", writes - base, 100);
        chk("abort_queue_empty", exp_q.size(), 0);

        // Reset in the middle of column 37
        slow_col   = 37;
        slow_delay = 40;
        repeat (3) @(negedge clk);
        vblank = 1'b1;
        wait_start(37);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_col_index", int'(job.col_index), 0);
        chk("midrst_overrun", int'(overrun), 0);
        chk("midrst_timeouts", int'(timeouts), 0);
        chk("midrst_col_start", int'(job.col_start), 0);
        chk("midrst_col_abort", int'(job.col_abort), 0);
        chk("midrst_buf_height", int'(job.buf_height), 0);
        vblank = 1'b0;
        @(negedge clk);
        chk("midrst_idle_next", int'(busy), 0);
        chk("midrst_queue_empty", exp_q.size(), 0);
        reset = 1'b1;

        // col_done on the same cycle as the vblank fall, column 200
        slow_col   = 200;
        slow_delay = 10;
        base       = writes;
        repeat (3) @(negedge clk);
        vblank = 1'b1;
        wait_start(200);
        chk("coinc_overrun_before", int'(overrun), 0);
        repeat (10) @(negedge clk);
        vblank = 1'b0;
        repeat (4) @(negedge clk);
        chk("coinc_writes", writes - base, 201);
        chk("coinc_overrun_after", int'(overrun), 1);
        chk("coinc_busy", int'(busy), 0);
        chk("coinc_no_abort", aborts, 1);
        chk("coinc_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
